// File: rtl/vector_shift_buffer.sv
// rtl/vector_shift_buffer.sv - serial-in / parallel-out word shift buffer with valid/ready on both sides
//
// Collects DEPTH words of WORD_WIDTH bits into one packed vector and hands it
// downstream as a single transfer. The oldest word sits in the MSBs and the
// newest in the LSBs. Back-to-back vectors stream at one word per cycle while
// out_ready stays high.
//
// Optional feature: define VECTOR_SHIFT_BUFFER_FLUSH_EN to add the flush port,
// which pads a partially filled vector with zero words and presents it at once.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   Sync_Reset   synchronous clear, same effect as reset, lower priority
//   flush        (VECTOR_SHIFT_BUFFER_FLUSH_EN only) pad and present a partial vector
//   in_valid     Data_Input holds a word
//   in_ready     buffer can take a word this cycle (combinational)
//   Data_Input   incoming word
//   out_valid    Data_Output holds a complete vector (registered)
//   out_ready    downstream consumes the vector this cycle
//   Data_Output  packed vector, oldest word in the MSBs
//   fill_count   words currently held, 0..DEPTH

module vector_shift_buffer #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Sync_Reset,
`ifdef VECTOR_SHIFT_BUFFER_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_WIDTH-1:0]         Data_Input,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_WIDTH*DEPTH-1:0]   Data_Output,
    output logic [CNT_W-1:0]              fill_count
);

    localparam int VEC_W = WORD_WIDTH * DEPTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q;

    logic               clear;
    logic               flush_act;
    logic               accept;
    logic               consume;
    logic [VEC_W-1:0]   shifted_vec;
    logic [VEC_W-1:0]   padded_vec;

    // Either clear source wins over every handshake in the same cycle.
    assign clear = reset | Sync_Reset;

`ifdef VECTOR_SHIFT_BUFFER_FLUSH_EN
    // Flush only means something for a partial vector still being filled.
    assign flush_act = flush && (state_q == ST_FILL) && (count_q != '0);

    // Move the held words up to the top of the vector and zero the slots
    // that were never filled.
    assign padded_vec = data_q << (WORD_WIDTH * (DEPTH - int'(count_q)));
`else
    assign flush_act  = 1'b0;
    assign padded_vec = data_q;
`endif

    always_comb begin
        in_ready = 1'b0;
        if (!clear) begin
            if (state_q == ST_FILL) begin
                in_ready = !flush_act;
            end else begin
                // A full buffer can take a word only while the vector leaves.
                in_ready = out_ready;
            end
        end
    end

    assign accept  = in_valid & in_ready;
    assign consume = out_valid_q & out_ready;

    // Shift form works for DEPTH==1 too, where the old word drops out entirely.
    assign shifted_vec = (data_q << WORD_WIDTH) | VEC_W'(Data_Input);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;

        if (clear) begin
            state_d = ST_FILL;
            data_d  = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (flush_act) begin
                        data_d  = padded_vec;
                        count_d = DEPTH_C;
                        state_d = ST_FULL;
                    end else if (accept) begin
                        data_d  = shifted_vec;
                        count_d = count_q + ONE_C;
                        if (count_q + ONE_C == DEPTH_C) begin
                            state_d = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    // Accept in FULL implies consume, since in_ready follows out_ready.
                    if (consume) begin
                        if (accept) begin
                            data_d  = shifted_vec;
                            count_d = ONE_C;
                            state_d = (DEPTH == 1) ? ST_FULL : ST_FILL;
                        end else begin
                            // Stale words are left in place; they shift out as
                            // the next vector arrives.
                            count_d = '0;
                            state_d = ST_FILL;
                        end
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            data_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            count_q     <= count_d;
            out_valid_q <= (state_d == ST_FULL);
        end
    end

    assign out_valid   = out_valid_q;
    assign Data_Output = data_q;
    assign fill_count  = count_q;

endmodule

// File: tb/tb_vector_shift_buffer.sv
// tb/tb_vector_shift_buffer.sv - self-checking bench for vector_shift_buffer (DEPTH=4 and DEPTH=1)
module tb_vector_shift_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sync_reset, in_valid, out_ready, flush;
    logic [7:0]  din;

    logic        in_ready4, out_valid4;
    logic [31:0] dout4;
    logic [2:0]  cnt4;
    logic        in_ready1, out_valid1;
    logic [7:0]  dout1;
    logic [0:0]  cnt1;

    vector_shift_buffer #(.WORD_WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk),
        .reset(reset),
        .Sync_Reset(sync_reset),
`ifdef VECTOR_SHIFT_BUFFER_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready4),
        .Data_Input(din),
        .out_valid(out_valid4),
        .out_ready(out_ready),
        .Data_Output(dout4),
        .fill_count(cnt4)
    );

    vector_shift_buffer #(.WORD_WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk(clk),
        .reset(reset),
        .Sync_Reset(sync_reset),
`ifdef VECTOR_SHIFT_BUFFER_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready1),
        .Data_Input(din),
        .out_valid(out_valid1),
        .out_ready(out_ready),
        .Data_Output(dout1),
        .fill_count(cnt1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, the last DEPTH words ever shifted in
    // (oldest first) plus the number of words belonging to the current vector.
    int         m_depth[2] = '{4, 1};
    int         m_cnt[2];
    logic [7:0] m_hist[2][$];

    function automatic logic flush_on();
`ifdef VECTOR_SHIFT_BUFFER_FLUSH_EN
        return flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset(input int k);
        m_hist[k].delete();
        for (int i = 0; i < m_depth[k]; i++) m_hist[k].push_back(8'h00);
        m_cnt[k] = 0;
    endtask

    task automatic model_push(input int k, input logic [7:0] w);
        m_hist[k].push_back(w);
        void'(m_hist[k].pop_front());
    endtask

    function automatic logic exp_in_ready(input int k);
        if (reset || sync_reset) return 1'b0;
        if (m_cnt[k] < m_depth[k]) return !(flush_on() && m_cnt[k] > 0);
        return out_ready;
    endfunction

    function automatic logic [31:0] exp_vec(input int k);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < m_depth[k]; i++) v = (v << 8) | 32'(m_hist[k][i]);
        return v;
    endfunction

    task automatic model_update(input int k);
        logic acc;
        acc = in_valid && exp_in_ready(k);
        if (reset || sync_reset) begin
            model_reset(k);
        end else if (m_cnt[k] < m_depth[k] && m_cnt[k] > 0 && flush_on()) begin
            for (int i = m_cnt[k]; i < m_depth[k]; i++) model_push(k, 8'h00);
            m_cnt[k] = m_depth[k];
        end else begin
            if (m_cnt[k] == m_depth[k] && out_ready) m_cnt[k] = 0;
            if (acc) begin
                model_push(k, din);
                m_cnt[k]++;
            end
        end
    endtask

    // Check both instances against the model mid-cycle, then advance one edge.
    task automatic step();
        @(negedge clk);
        check("d4.in_ready",  32'(in_ready4),  32'(exp_in_ready(0)));
        check("d4.out_valid", 32'(out_valid4), 32'(m_cnt[0] == m_depth[0]));
        check("d4.data",      dout4,           exp_vec(0));
        check("d4.count",     32'(cnt4),       32'(m_cnt[0]));
        check("d1.in_ready",  32'(in_ready1),  32'(exp_in_ready(1)));
        check("d1.out_valid", 32'(out_valid1), 32'(m_cnt[1] == m_depth[1]));
        check("d1.data",      32'(dout1),      exp_vec(1));
        check("d1.count",     32'(cnt1),       32'(m_cnt[1]));
        model_update(0);
        model_update(1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        in_valid = 1'b1;
        din      = w;
        step();
        in_valid = 1'b0;
    endtask

    logic       acc0;
    logic [7:0] words4[4];

    initial begin
        reset = 1'b1; sync_reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        flush = 1'b0; din = 8'h00;
        @(posedge clk); #1;
        model_reset(0);
        model_reset(1);
        step();                       // reset still high: in_ready must be 0
        reset = 1'b0;

        // Fill one vector with downstream stalled.
        words4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send(words4[i]);
        check("s1.data", dout4, 32'h11223344);
        check("s1.valid", 32'(out_valid4), 32'd1);
        check("s1.count", 32'(cnt4), 32'd4);
        in_valid = 1'b1; din = 8'h99;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        check("s1.frozen", dout4, 32'h11223344);

        // Consume and accept in the same cycle, then refill.
        out_ready = 1'b1;
        send(8'h55);
        out_ready = 1'b0;
        check("s2.valid", 32'(out_valid4), 32'd0);
        check("s2.count", 32'(cnt4), 32'd1);
        check("s2.lsb", 32'(dout4[7:0]), 32'h55);
        send(8'h66); send(8'h77); send(8'h88);
        check("s2.data", dout4, 32'h55667788);
        check("s2.valid2", 32'(out_valid4), 32'd1);

        // Sync_Reset mid-fill overrides a presented word.
        out_ready = 1'b1; step(); out_ready = 1'b0;
        send(8'hA1); send(8'hA2);
        sync_reset = 1'b1;
        send(8'hA3);
        sync_reset = 1'b0;
        check("s3.data", dout4, 32'h0);
        check("s3.count", 32'(cnt4), 32'd0);

        // Reset while full with downstream ready.
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i));
        reset = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b0;
        check("s4.data", dout4, 32'h0);
        check("s4.valid", 32'(out_valid4), 32'd0);

`ifdef VECTOR_SHIFT_BUFFER_FLUSH_EN
        send(8'hAA); send(8'hBB);
        flush = 1'b1; step(); flush = 1'b0;
        check("s5.data", dout4, 32'hAABB0000);
        check("s5.count", 32'(cnt4), 32'd4);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        check("s5.idle_count", 32'(cnt4), 32'd0);
        check("s5.idle_valid", 32'(out_valid4), 32'd0);
`endif

        // DEPTH=1 streaming.
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din = 8'(i);
            step();
            check("s6.data", 32'(dout1), 32'(i));
            check("s6.valid", 32'(out_valid1), 32'd1);
            check("s6.count", 32'(cnt1), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Randomized traffic; a word not accepted by the DEPTH=4 buffer is held.
        acc0 = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (acc0 || !in_valid) begin
                in_valid = ($urandom_range(0, 9) < 7);
                din      = 8'($urandom);
            end
            out_ready  = ($urandom_range(0, 9) < 6);
            sync_reset = ($urandom_range(0, 99) < 2);
            reset      = ($urandom_range(0, 99) < 1);
            flush      = ($urandom_range(0, 99) < 5);
            acc0 = in_valid && exp_in_ready(0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
